// File: rtl/altera_tse_pcs_pkg.sv
// Shared PCS definitions: receive-sync state encodings, K28.5 and state-range helpers.
package altera_tse_pcs_pkg;

    typedef enum logic [3:0] {
        ST_LOS  = 4'd0,
        ST_CD1  = 4'd1,
        ST_AS1  = 4'd2,
        ST_CD2  = 4'd3,
        ST_AS2  = 4'd4,
        ST_CD3  = 4'd5,
        ST_SA1  = 4'd6,
        ST_SA2  = 4'd7,
        ST_SA2A = 4'd8,
        ST_SA3  = 4'd9,
        ST_SA3A = 4'd10,
        ST_SA4  = 4'd11,
        ST_SA4A = 4'd12
    } sync_state_t;

    localparam logic [7:0] K28_5    = 8'hBC;
    localparam logic [3:0] SA_FIRST = 4'd6;
    localparam logic [3:0] SA_LAST  = 4'd12;

    function automatic logic is_sync_acq(input sync_state_t s);
        return (s >= SA_FIRST) && (s <= SA_LAST);
    endfunction

    function automatic logic is_comma_det(input sync_state_t s);
        return (s == ST_CD1) || (s == ST_CD2) || (s == ST_CD3);
    endfunction

    // Un-primed SYNC_ACQUIRED levels; entering one restarts the good-group run.
    function automatic logic is_sa_base(input sync_state_t s);
        return (s == ST_SA2) || (s == ST_SA3) || (s == ST_SA4);
    endfunction

endpackage

// File: rtl/altera_tse_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module altera_tse_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/altera_tse_rx_link_sync.sv
// 1000BASE-X receive synchronization FSM: qualifies comma alignment, tracks rx_even,
// registers the code-group stream and counts loss-of-sync events.
module altera_tse_rx_link_sync
    import altera_tse_pcs_pkg::*;
#(
    parameter bit DISPERR_IS_INVALID = 1'b1,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_ena,
    input  logic                 rx_signal_detect,
    input  logic [7:0]           rx_data,
    input  logic                 rx_kchar,
    input  logic                 rx_errdetect,
    input  logic                 rx_disperr,
    input  logic                 cnt_clear,
    output logic [7:0]           pcs_data,
    output logic                 pcs_kchar,
    output logic                 pcs_cgbad,
    output logic                 pcs_valid,
    output logic                 sync_status,
    output logic                 rx_even,
    output logic [3:0]           sync_state,
    output logic [CNT_WIDTH-1:0] loss_cnt
);

    sync_state_t state, state_nx;
    logic [1:0]  good_cgs, good_nx;
    logic        even_nx, sync_nx;
    logic        invalid, comma, cgbad, is_d;

    always_comb begin
        invalid  = rx_errdetect | (rx_disperr & DISPERR_IS_INVALID);
        comma    = rx_kchar & (rx_data == K28_5) & ~invalid;
        cgbad    = invalid | (comma & rx_even);
        is_d     = ~rx_kchar & ~invalid;
        state_nx = state;
        good_nx  = good_cgs;

        if (rx_ena) begin
            case (state)
                ST_LOS: if (comma) state_nx = ST_CD1;
                ST_CD1: state_nx = is_d ? ST_AS1 : ST_LOS;
                ST_CD2: state_nx = is_d ? ST_AS2 : ST_LOS;
                ST_CD3: state_nx = is_d ? ST_SA1 : ST_LOS;
                ST_AS1, ST_AS2: begin
                    if (cgbad)
                        state_nx = ST_LOS;
                    else if (comma && !rx_even)
                        state_nx = (state == ST_AS1) ? ST_CD2 : ST_CD3;
                end
                ST_SA1: if (cgbad) state_nx = ST_SA2;
                // SAn -> SAnA is +1, SAn -> SA(n+1) is +2 in the encoding
                ST_SA2, ST_SA3, ST_SA4: begin
                    if (cgbad) begin
                        state_nx = (state == ST_SA4) ? ST_LOS : sync_state_t'(state + 4'd2);
                    end else begin
                        state_nx = sync_state_t'(state + 4'd1);
                        good_nx  = 2'd1;
                    end
                end
                ST_SA2A, ST_SA3A, ST_SA4A: begin
                    if (cgbad)
                        state_nx = (state == ST_SA4A) ? ST_LOS : sync_state_t'(state + 4'd1);
                    else if (good_cgs == 2'd3)
                        state_nx = (state == ST_SA2A) ? ST_SA1 : sync_state_t'(state - 4'd3);
                    else
                        good_nx = good_cgs + 2'd1;
                end
                default: state_nx = ST_LOS;
            endcase
        end

        if (!rx_signal_detect)
            state_nx = ST_LOS;

        if (is_sa_base(state_nx) && (state_nx != state))
            good_nx = 2'd0;

        if (is_comma_det(state_nx) && (state_nx != state))
            even_nx = 1'b1;
        else
            even_nx = rx_ena ? ~rx_even : rx_even;

        sync_nx = is_sync_acq(state_nx);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_LOS;
            good_cgs    <= 2'd0;
            rx_even     <= 1'b0;
            sync_status <= 1'b0;
        end else begin
            state       <= state_nx;
            good_cgs    <= good_nx;
            rx_even     <= even_nx;
            sync_status <= sync_nx;
        end
    end

    // cgbad is registered with the rx_even in force when the group arrived.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcs_data  <= 8'd0;
            pcs_kchar <= 1'b0;
            pcs_cgbad <= 1'b0;
            pcs_valid <= 1'b0;
        end else begin
            pcs_data  <= rx_data;
            pcs_kchar <= rx_kchar;
            pcs_cgbad <= cgbad;
            pcs_valid <= rx_ena;
        end
    end

    assign sync_state = state;

    altera_tse_sat_counter #(.WIDTH(CNT_WIDTH)) u_loss_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .inc     (sync_status & ~sync_nx),
        .count   (loss_cnt)
    );

endmodule

// File: tb/tb_altera_tse_rx_link_sync.sv
// Bench for altera_tse_rx_link_sync: three configurations driven in parallel and
// compared against an abstract acquisition/level model of the sync process.
`timescale 1ns/1ps
module tb_altera_tse_rx_link_sync;

    // ph: 0 lost, 1 comma seen, 2 aligning, 3 synced; kc = commas seen; lvl = sync level 1..4
    typedef struct {
        int         ph, kc, lvl, ina, good, loss, loss2;
        bit         even, sync, pk, pb, pv;
        logic [7:0] pd;
    } mst_t;

    logic       clk = 1'b0, reset_n = 1'b0;
    logic       rx_ena = 1'b0, rx_signal_detect = 1'b0, rx_kchar = 1'b0;
    logic       rx_errdetect = 1'b0, rx_disperr = 1'b0, cnt_clear = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic [7:0] pdat [3];
    logic       pk [3], pb [3], pv [3], ss [3], ev [3];
    logic [3:0] st [3];
    logic [15:0] lca, lcb;
    logic [1:0]  lc2;
    int   vectors = 0, miscompares = 0;
    mst_t m1, m0;

    always #5 clk = ~clk;

    altera_tse_rx_link_sync #(.DISPERR_IS_INVALID(1'b1), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .rx_ena(rx_ena), .rx_signal_detect(rx_signal_detect),
        .rx_data(rx_data), .rx_kchar(rx_kchar), .rx_errdetect(rx_errdetect),
        .rx_disperr(rx_disperr), .cnt_clear(cnt_clear), .pcs_data(pdat[0]), .pcs_kchar(pk[0]),
        .pcs_cgbad(pb[0]), .pcs_valid(pv[0]), .sync_status(ss[0]), .rx_even(ev[0]),
        .sync_state(st[0]), .loss_cnt(lca));

    altera_tse_rx_link_sync #(.DISPERR_IS_INVALID(1'b0), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .rx_ena(rx_ena), .rx_signal_detect(rx_signal_detect),
        .rx_data(rx_data), .rx_kchar(rx_kchar), .rx_errdetect(rx_errdetect),
        .rx_disperr(rx_disperr), .cnt_clear(cnt_clear), .pcs_data(pdat[1]), .pcs_kchar(pk[1]),
        .pcs_cgbad(pb[1]), .pcs_valid(pv[1]), .sync_status(ss[1]), .rx_even(ev[1]),
        .sync_state(st[1]), .loss_cnt(lcb));

    altera_tse_rx_link_sync #(.DISPERR_IS_INVALID(1'b1), .CNT_WIDTH(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .rx_ena(rx_ena), .rx_signal_detect(rx_signal_detect),
        .rx_data(rx_data), .rx_kchar(rx_kchar), .rx_errdetect(rx_errdetect),
        .rx_disperr(rx_disperr), .cnt_clear(cnt_clear), .pcs_data(pdat[2]), .pcs_kchar(pk[2]),
        .pcs_cgbad(pb[2]), .pcs_valid(pv[2]), .sync_status(ss[2]), .rx_even(ev[2]),
        .sync_state(st[2]), .loss_cnt(lc2));

    function automatic mst_t mrst();
        mst_t r;
        r.ph = 0; r.kc = 0; r.lvl = 1; r.ina = 0; r.good = 0; r.loss = 0; r.loss2 = 0;
        r.even = 0; r.sync = 0; r.pk = 0; r.pb = 0; r.pv = 0; r.pd = 8'd0;
        return r;
    endfunction

    function automatic int enc(input mst_t m);
        if (m.ph == 0) return 0;
        if (m.ph == 1) return 2 * m.kc - 1;
        if (m.ph == 2) return 2 * m.kc;
        return (m.lvl == 1) ? 6 : 2 * m.lvl + 3 + m.ina;
    endfunction

    function automatic mst_t worse(input mst_t s);
        mst_t n = s;
        if (s.lvl == 4) n.ph = 0;
        else begin n.lvl = s.lvl + 1; n.ina = 0; n.good = 0; end
        return n;
    endfunction

    function automatic mst_t mstep(input mst_t s, input bit ena, sd, k, err, disp, clr, dinv,
                                   input logic [7:0] d);
        mst_t n;
        bit inv, comma, bad;
        n     = s;
        inv   = err | (disp & dinv);
        comma = k && (d == 8'hBC) && !inv;
        bad   = inv | (comma & s.even);
        n.pd = d; n.pk = k; n.pb = bad; n.pv = ena;
        if (ena) begin
            n.even = !s.even;
            if (sd) begin
                case (s.ph)
                    0: if (comma) begin n.ph = 1; n.kc = 1; n.even = 1; end
                    1: if (!k && !inv) begin
                           if (s.kc == 3) begin n.ph = 3; n.lvl = 1; n.ina = 0; end
                           else n.ph = 2;
                       end else n.ph = 0;
                    2: if (bad) n.ph = 0;
                       else if (comma && !s.even) begin n.ph = 1; n.kc = s.kc + 1; n.even = 1; end
                    default: begin
                        if (bad) n = worse(n);
                        else if (s.lvl > 1 && s.ina == 0) begin n.ina = 1; n.good = 1; end
                        else if (s.lvl > 1 && s.good == 3) begin n.lvl = s.lvl - 1; n.ina = 0; n.good = 0; end
                        else if (s.lvl > 1) n.good = s.good + 1;
                    end
                endcase
            end
        end
        if (!sd) n.ph = 0;
        n.sync = (n.ph == 3);
        if (clr) begin n.loss = 0; n.loss2 = 0; end
        else if (s.sync && !n.sync) begin
            if (n.loss < 65535) n.loss++;
            if (n.loss2 < 3) n.loss2++;
        end
        return n;
    endfunction

    task automatic cyc(input bit ena, sd, k, err, disp, clr, input logic [7:0] d);
        rx_ena = ena; rx_signal_detect = sd; rx_kchar = k; rx_errdetect = err;
        rx_disperr = disp; cnt_clear = clr; rx_data = d;
        @(posedge clk);
        m1 = mstep(m1, ena, sd, k, err, disp, clr, 1'b1, d);
        m0 = mstep(m0, ena, sd, k, err, disp, clr, 1'b0, d);
        #1;
    endtask

    task automatic k28();  cyc(1, 1, 1, 0, 0, 0, 8'hBC); endtask
    task automatic d162(); cyc(1, 1, 0, 0, 0, 0, 8'h50); endtask
    task automatic go_los(); cyc(1, 0, 0, 0, 0, 0, 8'h00); endtask
    task automatic acquire(); repeat (3) begin k28(); d162(); end endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({st[i], ss[i], ev[i], pdat[i], pk[i], pb[i], pv[i]} !== 16'd0 ||
                lca !== 16'd0 || lcb !== 16'd0 || lc2 !== 2'd0) begin
                miscompares++;
                $display("FAIL reset dut%0d: got st=%0d ss=%b ev=%b pcs=%h/%b/%b/%b loss=%0d/%0d/%0d want all 0",
                         i, st[i], ss[i], ev[i], pdat[i], pk[i], pb[i], pv[i], lca, lcb, lc2);
            end
        end
        m1 = mrst(); m0 = mrst();
        @(negedge clk);
        reset_n = 1'b1; rx_signal_detect = 1'b1;
    endtask

    task automatic test_acquisition();
        int exp_st [6];
        exp_st = '{1, 2, 3, 4, 5, 6};
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) k28(); else d162();
            vectors++;
            if (st[0] !== 4'(exp_st[i]) || ss[0] !== 1'(i == 5)) begin
                miscompares++;
                $display("FAIL acquisition step %0d: got st=%0d ss=%b want st=%0d ss=%b",
                         i, st[0], ss[0], exp_st[i], (i == 5));
            end
        end
    endtask

    task automatic test_odd_comma();
        int exp_st [4];
        exp_st = '{8, 8, 8, 6};
        d162(); k28();
        vectors++;
        if (st[0] !== 4'd7 || ss[0] !== 1'b1 || pb[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL odd_comma: got st=%0d ss=%b cgbad=%b want st=7 ss=1 cgbad=1", st[0], ss[0], pb[0]);
        end
        for (int i = 0; i < 4; i++) begin
            d162();
            vectors++;
            if (st[0] !== 4'(exp_st[i]) || ss[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL odd_comma recover %0d: got st=%0d ss=%b want st=%0d ss=1",
                         i, st[0], ss[0], exp_st[i]);
            end
        end
    endtask

    task automatic test_loss();
        int exp_st [4];
        exp_st = '{7, 9, 11, 0};
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 1, 0, 0, 8'h50);
            vectors++;
            if (st[0] !== 4'(exp_st[i])) begin
                miscompares++;
                $display("FAIL loss step %0d: got st=%0d want %0d", i, st[0], exp_st[i]);
            end
        end
        vectors++;
        if (ss[0] !== 1'b0 || lca !== 16'd1) begin
            miscompares++;
            $display("FAIL loss result: got ss=%b loss=%0d want ss=0 loss=1", ss[0], lca);
        end
    endtask

    task automatic test_disparity();
        go_los(); acquire();
        repeat (10) cyc(1, 1, 0, 0, 1, 0, 8'h50);
        vectors++;
        if (st[1] !== 4'd6 || st[0] !== 4'd0 || st[2] !== 4'd0 || ss[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL disparity: got st ign=%0d inv=%0d inv2=%0d ss_ign=%b want 6/0/0/1",
                     st[1], st[0], st[2], ss[1]);
        end
        vectors++;
        if (lca !== 16'(m1.loss) || lcb !== 16'(m0.loss)) begin
            miscompares++;
            $display("FAIL disparity loss: got %0d/%0d want %0d/%0d", lca, lcb, m1.loss, m0.loss);
        end
    endtask

    task automatic test_enable();
        go_los(); k28(); d162(); k28();
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 1'($urandom), 1'($urandom), 0, 0, 8'($urandom));
            vectors++;
            if (st[0] !== 4'd3 || st[1] !== 4'd3 || pv[0] !== 1'b0 || ev[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL enable hold %0d: got st=%0d/%0d valid=%b ev=%b want 3/3 0 1",
                         i, st[0], st[1], pv[0], ev[0]);
            end
        end
        d162();
        vectors++;
        if (st[0] !== 4'd4 || pv[0] !== 1'b1 || pdat[0] !== 8'h50) begin
            miscompares++;
            $display("FAIL enable resume: got st=%0d valid=%b data=%h want 4 1 50", st[0], pv[0], pdat[0]);
        end
    endtask

    task automatic test_signal_detect();
        go_los(); acquire();
        cyc(1, 0, 0, 0, 0, 0, 8'h50);
        vectors++;
        if (st[0] !== 4'd0 || ss[0] !== 1'b0 || lca !== 16'(m1.loss)) begin
            miscompares++;
            $display("FAIL sigdet: got st=%0d ss=%b loss=%0d want 0 0 %0d", st[0], ss[0], lca, m1.loss);
        end
        acquire();
        cyc(0, 0, 0, 0, 0, 0, 8'h50);
        vectors++;
        if (st[0] !== 4'd0 || ss[0] !== 1'b0 || lca !== 16'(m1.loss)) begin
            miscompares++;
            $display("FAIL sigdet no-ena: got st=%0d ss=%b loss=%0d want 0 0 %0d", st[0], ss[0], lca, m1.loss);
        end
    endtask

    task automatic test_counter();
        cyc(1, 1, 0, 0, 0, 1, 8'h50);
        vectors++;
        if (lc2 !== 2'd0 || lca !== 16'd0) begin
            miscompares++;
            $display("FAIL counter clear: got %0d/%0d want 0/0", lca, lc2);
        end
        repeat (5) begin acquire(); go_los(); end
        vectors++;
        if (lc2 !== 2'd3 || lca !== 16'd5) begin
            miscompares++;
            $display("FAIL counter saturate: got w16=%0d w2=%0d want 5 3", lca, lc2);
        end
        acquire();
        cyc(1, 0, 0, 0, 0, 1, 8'h50);
        vectors++;
        if (lca !== 16'd0 || lcb !== 16'd0 || lc2 !== 2'd0 || ss[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL counter clear-vs-inc: got %0d/%0d/%0d ss=%b want 0/0/0 0", lca, lcb, lc2, ss[0]);
        end
    endtask

    task automatic test_async_reset();
        acquire(); go_los();
        k28(); d162(); k28(); d162();
        vectors++;
        if (st[0] !== 4'd4 || lca !== 16'd1) begin
            miscompares++;
            $display("FAIL async setup: got st=%0d loss=%0d want 4 1", st[0], lca);
        end
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({st[i], ss[i], ev[i], pdat[i], pk[i], pb[i], pv[i]} !== 16'd0 ||
                lca !== 16'd0 || lcb !== 16'd0 || lc2 !== 2'd0) begin
                miscompares++;
                $display("FAIL async reset dut%0d: got st=%0d ss=%b ev=%b pcs=%h/%b/%b/%b loss=%0d want all 0",
                         i, st[i], ss[i], ev[i], pdat[i], pk[i], pb[i], pv[i], lca);
            end
        end
        m1 = mrst(); m0 = mrst();
        @(negedge clk);
        reset_n = 1'b1;
        acquire();
        vectors++;
        if (st[0] !== 4'd6 || lca !== 16'd0) begin
            miscompares++;
            $display("FAIL async recover: got st=%0d loss=%0d want 6 0", st[0], lca);
        end
    endtask

    task automatic test_random();
        bit alt, ena, sd, clr, k, err, disp;
        int r, el, es;
        logic [7:0] d;
        logic [15:0] al;
        mst_t m;
        alt = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            r    = $urandom_range(99);
            ena  = ($urandom_range(9) != 0);
            sd   = ($urandom_range(99) != 0);
            clr  = ($urandom_range(49) == 0);
            k = 0; err = 0; disp = 0; d = 8'h50;
            if (r < 70) begin k = alt; d = alt ? 8'hBC : 8'h50; end
            else if (r < 80) d = 8'($urandom);
            else if (r < 86) begin err = 1; d = 8'($urandom); end
            else if (r < 91) disp = 1;
            else if (r < 95) begin k = 1; d = 8'h3C; end
            else begin k = 1; d = 8'hBC; end
            if (ena) alt = !alt;
            cyc(ena, sd, k, err, disp, clr, d);
            for (int i = 0; i < 3; i++) begin
                if (i == 1) m = m0; else m = m1;
                el = (i == 2) ? m.loss2 : m.loss;
                es = enc(m);
                al = (i == 0) ? lca : (i == 1) ? lcb : {14'd0, lc2};
                vectors++;
                if (st[i] !== 4'(es) || ss[i] !== m.sync || ev[i] !== m.even || al !== 16'(el) ||
                    pdat[i] !== m.pd || pk[i] !== m.pk || pv[i] !== m.pv ||
                    (m.pv && pb[i] !== m.pb)) begin
                    miscompares++;
                    $display("FAIL random cyc %0d dut%0d: got st=%0d ss=%b ev=%b loss=%0d pcs=%h/%b/%b/%b want st=%0d ss=%b ev=%b loss=%0d pcs=%h/%b/%b/%b",
                             n, i, st[i], ss[i], ev[i], al, pdat[i], pk[i], pb[i], pv[i],
                             es, m.sync, m.even, el, m.pd, m.pk, m.pb, m.pv);
                end
            end
        end
    endtask

    initial begin
        m1 = mrst(); m0 = mrst();
        test_reset();
        test_acquisition();
        test_odd_comma();
        test_loss();
        test_disparity();
        test_enable();
        test_signal_detect();
        test_counter();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/altera_tse_rx_link_sync.md
Name: altera_tse_rx_link_sync

Overview:
- 1000BASE-X receive synchronization state machine (IEEE 802.3 Clause 36, Fig. 36-9).
- Sits between the transceiver's decoded 8b/10b receive outputs (data, control flag, code-error, disparity-error) and the PCS receive path.
- Qualifies code-group alignment and produces sync_status and the rx_even parity.
- Delivers a 1-cycle-registered copy of the code-group stream with per-group validity, plus a loss-of-sync event counter for the register map.

Parameters:
- DISPERR_IS_INVALID, 1: 1 = a disparity error counts as an invalid code-group; 0 = ignored for sync.
- CNT_WIDTH, 16: width of the loss-of-sync counter; counter saturates.

Ports:
- clk  in  1  receive PCS clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_ena  in  1  code-group strobe; all state and counters advance only when 1.
- rx_signal_detect  in  1  1 = signal present; 0 forces LOSS_OF_SYNC.
- rx_data  in  8  decoded code-group.
- rx_kchar  in  1  1 = control code-group.
- rx_errdetect  in  1  invalid 10b code.
- rx_disperr  in  1  running-disparity error.
- cnt_clear  in  1  synchronous clear of loss_cnt (priority over increment).
- pcs_data  out  8  registered rx_data.
- pcs_kchar  out  1  registered rx_kchar.
- pcs_cgbad  out  1  registered cgbad for this group.
- pcs_valid  out  1  registered rx_ena.
- sync_status  out  1  1 in SYNC_ACQ_* states.
- rx_even  out  1  even/odd code-group parity.
- sync_state  out  4  current state encoding (debug).
- loss_cnt  out  CNT_WIDTH  count of sync_status 1->0 transitions.

Behaviour:
- Reset: all outputs 0; state LOSS_OF_SYNC; good_cgs 0; rx_even 0.
- Per-group terms, evaluated only when rx_ena=1:
  - invalid = rx_errdetect | (rx_disperr & DISPERR_IS_INVALID).
  - comma = rx_kchar & rx_data==8'hBC & !invalid.
  - cgbad = invalid | (comma & rx_even).
  - cggood = !cgbad.
  - isD = !rx_kchar & !invalid.
- rx_even update: rx_even <= 1 on any transition into a COMMA_DET state; otherwise rx_even <= !rx_even on every accepted group.
- States and encodings:
  - LOS 0: on comma -> CD1; else stay.
  - CD1 1 / CD2 3 / CD3 5: isD -> AS1 / AS2 / SA1 respectively; else -> LOS.
  - AS1 2 / AS2 4:
    - cgbad -> LOS.
    - comma & !rx_even -> CD2 / CD3 respectively.
    - otherwise stay.
  - SA1 6: cgbad -> SA2; else stay.
  - SA2 7 / SA3 9 / SA4 11:
    - On entry, good_cgs <= 0.
    - cggood -> SAnA (8 / 10 / 12) with good_cgs <= 1.
    - cgbad -> next level (SA4 -> LOS).
  - SAnA:
    - cgbad -> SA(n+1), or LOS from SA4A.
    - cggood & good_cgs==3 -> SA(n-1), with SA2A -> SA1.
    - cggood & good_cgs<3 -> good_cgs++.
- sync_status = registered (state in 6..12); it updates in the same cycle as the state register.
- rx_signal_detect=0: next state LOS regardless of rx_ena (asynchronous in effect, synchronous in implementation). Has priority over every other transition.
- loss_cnt:
  - +1 on any cycle where sync_status goes 1 -> 0.
  - Saturates at all-ones.
  - cnt_clear in the same cycle as an increment wins; result 0.
- Data path: pcs_* <= inputs every clk, regardless of state. Latency exactly 1 cycle. pcs_cgbad uses the pre-update rx_even.
- rx_ena=0: state, rx_even, good_cgs hold; pcs_valid=0 next cycle.
- Mid-operation reset: immediate return to reset values. loss_cnt is not incremented by reset.

Decomposition:
- Shared package altera_tse_pcs_pkg holds:
  - State enum.
  - K28.5 constant 8'hBC.
  - Helper predicate constants for SA state ranges.
- Optional sub-module altera_tse_sat_counter (parameterised width, clear, increment, saturate), reused for the PCS error counters.

Test Plan:
- Acquisition: signal_detect=1, stream K28.5,D16.2 x3 -> sync_status=1 exactly after the 3rd D16.2 is registered. sync_state sequence 0,1,2,3,4,5,6.
- Odd-position comma: after sync, insert K28.5 at odd position -> state 7, sync_status stays 1. Then 4 good groups -> state 6.
- Loss: in SA1, 4 consecutive rx_errdetect groups -> states 7,9,11,0; sync_status=0; loss_cnt=1.
- Disparity: DISPERR_IS_INVALID=0, 10 groups with rx_disperr=1 -> remains state 6. DISPERR_IS_INVALID=1, same stimulus -> LOS.
- Enable/signal: rx_ena low for 20 cycles mid-acquisition -> state frozen. Deassert rx_signal_detect while in SA1 -> LOS next cycle, loss_cnt+1.
- Counter: CNT_WIDTH=2, force 5 losses -> loss_cnt=3. cnt_clear coincident with a loss -> 0. Async reset_n pulse mid-AS2 -> all outputs 0 immediately.
